// File: rtl/traffic_pkg.sv
// Shared traffic package: default timing parameters, hour-of-day range and
// the low-traffic window decode used by the controller and input conditioner.
package traffic_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int EMERG_HOLD_DEF      = 8;
    localparam int LT_START_DEF        = 0;
    localparam int LT_END_DEF          = 5;
    localparam int HOUR_MIN            = 0;
    localparam int HOUR_MAX            = 23;
    localparam int HOUR_W              = 5;

    // Window [lt_start, lt_end); lt_start > lt_end wraps past midnight,
    // equal bounds mean an empty window, out-of-range hours never match.
    function automatic logic in_low_traffic(input logic [HOUR_W-1:0] hour,
                                            input int lt_start,
                                            input int lt_end);
        int   h;
        logic hit;
        h = {{(32-HOUR_W){1'b0}}, hour};
        if ((h < HOUR_MIN) || (h > HOUR_MAX))
            hit = 1'b0;
        else if (lt_start < lt_end)
            hit = (h >= lt_start) && (h < lt_end);
        else if (lt_start > lt_end)
            hit = (h >= lt_start) || (h < lt_end);
        else
            hit = 1'b0;
        return hit;
    endfunction

endpackage

// File: rtl/traffic_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// A stable raw level reaches 'level' CYCLES+2 rising edges after first sampled.
module traffic_debounce
    import traffic_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] cnt;

    // Bring the asynchronous input into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Flip the filtered level after CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == 4'(CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync_p1;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/traffic_input_conditioner.sv
// Conditions raw roadside inputs for the traffic controller: debounced car
// presence, latched pedestrian request, hold-extended emergency, gate pulses
// and a registered time-of-day low-traffic flag.
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int EMERG_HOLD      = EMERG_HOLD_DEF,
    parameter int LT_START        = LT_START_DEF,
    parameter int LT_END          = LT_END_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              raw_car_sensor,
    input  logic              raw_ped_button,
    input  logic              raw_emergency,
    input  logic              raw_gate_in,
    input  logic              raw_gate_out,
    input  logic [HOUR_W-1:0] hour,
    input  logic              pedestrian_green,
    output logic              car_sensor,
    output logic              pedestrian_req,
    output logic              emergency,
    output logic              car_enter,
    output logic              car_exit,
    output logic              low_traffic_mode
);

    logic       ped_filt;
    logic       emerg_filt;
    logic       gin_filt;
    logic       gout_filt;
    logic       ped_prev;
    logic       gin_prev;
    logic       gout_prev;
    logic       ped_rise;
    logic       gin_rise;
    logic       gout_rise;
    logic [3:0] hold_cnt;

    traffic_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_car (
        .clk(clk), .reset(reset), .raw(raw_car_sensor), .level(car_sensor));
    traffic_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ped (
        .clk(clk), .reset(reset), .raw(raw_ped_button), .level(ped_filt));
    traffic_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_emerg (
        .clk(clk), .reset(reset), .raw(raw_emergency), .level(emerg_filt));
    traffic_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_gate_in (
        .clk(clk), .reset(reset), .raw(raw_gate_in), .level(gin_filt));
    traffic_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_gate_out (
        .clk(clk), .reset(reset), .raw(raw_gate_out), .level(gout_filt));

    assign ped_rise  = ped_filt  & ~ped_prev;
    assign gin_rise  = gin_filt  & ~gin_prev;
    assign gout_rise = gout_filt & ~gout_prev;

    // Pedestrian latch: set on a filtered press, cleared by green (clear wins)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_prev       <= 1'b0;
            pedestrian_req <= 1'b0;
        end else begin
            ped_prev <= ped_filt;
            if (pedestrian_green)
                pedestrian_req <= 1'b0;
            else if (ped_rise)
                pedestrian_req <= 1'b1;
        end
    end

    // Emergency follows the filtered level, then holds EMERG_HOLD extra cycles;
    // a re-rise reloads the hold so the next fall gets the full count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            emergency <= 1'b0;
        end else if (emerg_filt) begin
            hold_cnt  <= 4'(EMERG_HOLD);
            emergency <= 1'b1;
        end else if (hold_cnt != 4'd0) begin
            hold_cnt  <= hold_cnt - 4'd1;
            emergency <= 1'b1;
        end else begin
            emergency <= 1'b0;
        end
    end

    // Gate pulses on filtered rising edges; coincident entry and exit cancel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gin_prev  <= 1'b0;
            gout_prev <= 1'b0;
            car_enter <= 1'b0;
            car_exit  <= 1'b0;
        end else begin
            gin_prev  <= gin_filt;
            gout_prev <= gout_filt;
            car_enter <= gin_rise & ~gout_rise;
            car_exit  <= gout_rise & ~gin_rise;
        end
    end

    // Registered low-traffic window decode of the RTC hour
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            low_traffic_mode <= 1'b0;
        else
            low_traffic_mode <= in_low_traffic(hour, LT_START, LT_END);
    end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner: default-parameter instance
// plus a midnight-wrap instance (LT_START=22, LT_END=3) sharing the inputs.
module tb_traffic_input_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       raw_car_sensor = 1'b0;
    logic       raw_ped_button = 1'b0;
    logic       raw_emergency = 1'b0;
    logic       raw_gate_in = 1'b0;
    logic       raw_gate_out = 1'b0;
    logic [4:0] hour = 5'd0;
    logic       pedestrian_green = 1'b0;

    logic car_sensor, pedestrian_req, emergency, car_enter, car_exit, low_traffic_mode;
    logic car2, ped2, em2, enter2, exit2, lt2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    traffic_input_conditioner dut (
        .clk(clk), .reset(reset),
        .raw_car_sensor(raw_car_sensor), .raw_ped_button(raw_ped_button),
        .raw_emergency(raw_emergency), .raw_gate_in(raw_gate_in),
        .raw_gate_out(raw_gate_out), .hour(hour),
        .pedestrian_green(pedestrian_green),
        .car_sensor(car_sensor), .pedestrian_req(pedestrian_req),
        .emergency(emergency), .car_enter(car_enter), .car_exit(car_exit),
        .low_traffic_mode(low_traffic_mode));

    traffic_input_conditioner #(.LT_START(22), .LT_END(3)) dut_wrap (
        .clk(clk), .reset(reset),
        .raw_car_sensor(raw_car_sensor), .raw_ped_button(raw_ped_button),
        .raw_emergency(raw_emergency), .raw_gate_in(raw_gate_in),
        .raw_gate_out(raw_gate_out), .hour(hour),
        .pedestrian_green(pedestrian_green),
        .car_sensor(car2), .pedestrian_req(ped2),
        .emergency(em2), .car_enter(enter2), .car_exit(exit2),
        .low_traffic_mode(lt2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got1, got2;
        hour = 5'd23;
        #2 reset = 1'b1;
        #1;
        step();
        step();
        got1 = {car_sensor, pedestrian_req, emergency, car_enter, car_exit, low_traffic_mode};
        got2 = {car2, ped2, em2, enter2, exit2, lt2};
        n_cmp++;
        if (got1 !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000", got1);
        end
        n_cmp++;
        if (got2 !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs_wrap: got %b expected 000000", got2);
        end
        reset = 1'b0;
        hour = 5'd10;
        step();
        step();
    endtask

    task automatic test_car_debounce();
        raw_car_sensor = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            n_cmp++;
            if (car_sensor !== (e >= 6)) begin
                n_fail++;
                $display("FAIL car_rise edge%0d: got %b expected %b", e, car_sensor, (e >= 6));
            end
        end
        raw_car_sensor = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            n_cmp++;
            if (car_sensor !== (e < 6)) begin
                n_fail++;
                $display("FAIL car_fall edge%0d: got %b expected %b", e, car_sensor, (e < 6));
            end
        end
        raw_car_sensor = 1'b1;
        step(); step(); step();
        raw_car_sensor = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_cmp++;
            if (car_sensor !== 1'b0) begin
                n_fail++;
                $display("FAIL car_glitch edge%0d: got %b expected 0", e, car_sensor);
            end
        end
    endtask

    task automatic test_gate_pulses();
        int n_in, n_out, pulse_edge;
        n_in = 0; n_out = 0; pulse_edge = -1;
        raw_gate_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (car_enter === 1'b1) begin n_in++; pulse_edge = e; end
            if (car_exit === 1'b1) n_out++;
        end
        raw_gate_in = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (car_enter === 1'b1) n_in++;
            if (car_exit === 1'b1) n_out++;
        end
        n_cmp++;
        if (n_in !== 1) begin
            n_fail++;
            $display("FAIL gate_in_count: got %0d expected 1", n_in);
        end
        n_cmp++;
        if (pulse_edge !== 7) begin
            n_fail++;
            $display("FAIL gate_in_edge: got %0d expected 7", pulse_edge);
        end
        n_cmp++;
        if (n_out !== 0) begin
            n_fail++;
            $display("FAIL gate_in_no_exit: got %0d expected 0", n_out);
        end
        n_in = 0; n_out = 0; pulse_edge = -1;
        raw_gate_out = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (car_exit === 1'b1) begin n_out++; pulse_edge = e; end
            if (car_enter === 1'b1) n_in++;
        end
        raw_gate_out = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        n_cmp++;
        if (n_out !== 1 || pulse_edge !== 7 || n_in !== 0) begin
            n_fail++;
            $display("FAIL gate_out_pulse: got exit=%0d edge=%0d enter=%0d expected 1/7/0",
                     n_out, pulse_edge, n_in);
        end
        n_in = 0; n_out = 0;
        raw_gate_in = 1'b1;
        raw_gate_out = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (car_enter === 1'b1) n_in++;
            if (car_exit === 1'b1) n_out++;
        end
        raw_gate_in = 1'b0;
        raw_gate_out = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        n_cmp++;
        if ((n_in + n_out) !== 0) begin
            n_fail++;
            $display("FAIL gate_simultaneous: got %0d pulses expected 0", n_in + n_out);
        end
    endtask

    task automatic test_pedestrian();
        raw_ped_button = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 7) raw_ped_button = 1'b0;
            n_cmp++;
            if (pedestrian_req !== (e >= 7)) begin
                n_fail++;
                $display("FAIL ped_latch edge%0d: got %b expected %b", e, pedestrian_req, (e >= 7));
            end
        end
        pedestrian_green = 1'b1;
        step();
        pedestrian_green = 1'b0;
        n_cmp++;
        if (pedestrian_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ped_clear: got %b expected 0", pedestrian_req);
        end
        for (int e = 1; e <= 4; e++) step();
        pedestrian_green = 1'b1;
        raw_ped_button = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            n_cmp++;
            if (pedestrian_req !== 1'b0) begin
                n_fail++;
                $display("FAIL ped_during_green edge%0d: got %b expected 0", e, pedestrian_req);
            end
        end
        pedestrian_green = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_cmp++;
            if (pedestrian_req !== 1'b0) begin
                n_fail++;
                $display("FAIL ped_no_relatch edge%0d: got %b expected 0", e, pedestrian_req);
            end
        end
        raw_ped_button = 1'b0;
        for (int e = 1; e <= 10; e++) step();
    endtask

    task automatic test_emergency_hold();
        logic exp;
        for (int e = 1; e <= 30; e++) begin
            raw_emergency = (e <= 10);
            step();
            exp = (e >= 7) && (e <= 24);
            n_cmp++;
            if (emergency !== exp) begin
                n_fail++;
                $display("FAIL emerg_hold edge%0d: got %b expected %b", e, emergency, exp);
            end
        end
        for (int e = 1; e <= 45; e++) begin
            raw_emergency = (e <= 10) || ((e >= 17) && (e <= 26));
            step();
            exp = (e >= 7) && (e <= 40);
            n_cmp++;
            if (emergency !== exp) begin
                n_fail++;
                $display("FAIL emerg_rerise edge%0d: got %b expected %b", e, emergency, exp);
            end
        end
    endtask

    task automatic test_low_traffic();
        logic [4:0] hrs [5];
        logic       exp [5];
        hrs = '{5'd23, 5'd0, 5'd4, 5'd5, 5'd24};
        exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            hour = hrs[i];
            step();
            n_cmp++;
            if (low_traffic_mode !== exp[i]) begin
                n_fail++;
                $display("FAIL lt_default hour%0d: got %b expected %b", hrs[i], low_traffic_mode, exp[i]);
            end
        end
        hrs = '{5'd23, 5'd10, 5'd22, 5'd3, 5'd2};
        exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            hour = hrs[i];
            step();
            n_cmp++;
            if (lt2 !== exp[i]) begin
                n_fail++;
                $display("FAIL lt_wrap hour%0d: got %b expected %b", hrs[i], lt2, exp[i]);
            end
        end
        hour = 5'd10;
        step();
    endtask

    task automatic test_reset_midstate();
        logic [5:0] got;
        raw_car_sensor = 1'b1;
        raw_ped_button = 1'b1;
        raw_emergency = 1'b1;
        for (int e = 1; e <= 7; e++) step();
        raw_emergency = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        n_cmp++;
        if ({pedestrian_req, emergency} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_state: got %b expected 11", {pedestrian_req, emergency});
        end
        raw_emergency = 1'b1;
        raw_gate_in = 1'b1;
        #2 reset = 1'b1;
        #1;
        got = {car_sensor, pedestrian_req, emergency, car_enter, car_exit, low_traffic_mode};
        n_cmp++;
        if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_immediate: got %b expected 000000", got);
        end
        step();
        step();
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            got = {car_sensor, pedestrian_req, emergency, car_enter, car_exit, 1'b0};
            n_cmp++;
            if (got !== {(e >= 6), (e >= 7), (e >= 7), (e == 7), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL requalify edge%0d: got %b expected %b", e, got,
                         {(e >= 6), (e >= 7), (e >= 7), (e == 7), 1'b0, 1'b0});
            end
        end
        raw_car_sensor = 1'b0;
        raw_ped_button = 1'b0;
        raw_emergency = 1'b0;
        raw_gate_in = 1'b0;
        pedestrian_green = 1'b1;
        step();
        pedestrian_green = 1'b0;
        for (int e = 1; e <= 20; e++) step();
    endtask

    initial begin
        test_reset();
        test_car_debounce();
        test_gate_pulses();
        test_pedestrian();
        test_emergency_hold();
        test_low_traffic();
        test_reset_midstate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
